// File: rtl/i2c_request_arbiter_if.sv
// Request/grant/completion bundle between requesters, the shared I2C transmitter and the arbiter.
// master = requester/transmitter side, slave = arbiter side.
interface i2c_request_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               trans_start;
  logic               xmit_done;
  logic [NUM_REQ-1:0] done;
  logic               xmit_abort;
  logic [NUM_REQ-1:0] timeout_err;
  logic               busy;

  modport master (
    output req, xmit_done,
    input  grant, trans_start, done, xmit_abort, timeout_err, busy
  );

  modport slave (
    input  req, xmit_done,
    output grant, trans_start, done, xmit_abort, timeout_err, busy
  );
endinterface

// File: rtl/i2c_request_arbiter.sv
// Round-robin owner of a shared I2C transmitter: grant 1 cycle after req, trans_start 2 cycles after, then hold until xmit_done.
// No backpressure on req (level, held by requester); optional BUSY watchdog under I2C_ARB_TIMEOUT_EN aborts with timeout_err.
module i2c_request_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input logic                    clock,
  input logic                    reset_n,
  i2c_request_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    GRANT   = 5'b00010,
    START   = 5'b00100,
    BUSY    = 5'b01000,
    RELEASE = 5'b10000
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] grant_c;
  logic               trans_start_c;
  logic [NUM_REQ-1:0] done_c;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0]        cnt_q, cnt_d;
  logic               abort_q, abort_d;
  logic               abort_c;
  logic [NUM_REQ-1:0] terr_c;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Search starts one past the previous owner so every requester is served in turn.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand    = '0;
    win_vld = 1'b0;
    win_idx = last_owner_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_owner_q + IDX_W'(k);
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      abort_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    grant_c       = '0;
    trans_start_c = 1'b0;
    done_c        = '0;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    abort_d       = abort_q;
    abort_c       = 1'b0;
    terr_c        = '0;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        grant_c[owner_q] = 1'b1;
        state_d          = START;
      end
      START: begin
        grant_c[owner_q] = 1'b1;
        trans_start_c    = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d            = '0;
        abort_d          = 1'b0;
`endif
        state_d          = BUSY;
      end
      BUSY: begin
        grant_c[owner_q] = 1'b1;
        // Completion wins over a watchdog expiry in the same cycle.
        if (bus.xmit_done) begin
          state_d = RELEASE;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT - 16'd1) begin
          abort_c = 1'b1;
          abort_d = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RELEASE: begin
`ifdef I2C_ARB_TIMEOUT_EN
        if (abort_q) terr_c[owner_q] = 1'b1;
        else         done_c[owner_q] = 1'b1;
        abort_d = 1'b0;
`else
        done_c[owner_q] = 1'b1;
`endif
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant       = grant_c;
  assign bus.trans_start = trans_start_c;
  assign bus.done        = done_c;
  assign bus.busy        = (state_q != IDLE);
`ifdef I2C_ARB_TIMEOUT_EN
  assign bus.xmit_abort  = abort_c;
  assign bus.timeout_err = terr_c;
`else
  assign bus.xmit_abort  = 1'b0;
  assign bus.timeout_err = '0;
`endif

endmodule
